ems_page_loader: RTL and testbench

EMS_PAGE_LOADER -- requirements
Module: ems_page_loader

---
 rtl/ems_page_loader.sv | 193 +++++++++++++++++++
 tb/tb_ems_page_loader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ems_page_loader.sv
// EMS page loader: writes four page registers and then the control register over Wishbone.
// Build option EMS_LOADER_VERIFY_EN adds a read-back pass that checks every written byte.
module ems_page_loader #(
  parameter logic [15:0] IO_BASE_ADDR   = 16'h0208,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        start_i,
  input  logic [7:0]  page0_i,
  input  logic [7:0]  page1_i,
  input  logic [7:0]  page2_i,
  input  logic [7:0]  page3_i,
  input  logic [3:0]  umb_base_i,
  input  logic        enable_i,
  output logic [14:0] wbm_adr_o,
  output logic [15:0] wbm_dat_o,
  input  logic [15:0] wbm_dat_i,
  output logic [1:0]  wbm_sel_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  input  logic        wbm_ack_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [2:0]  err_idx_o
);

  typedef enum logic [1:0] {IDLE, REQ, GAP, FINISH} state_t;

  localparam logic [14:0] BASE_WORD = IO_BASE_ADDR[15:1];
  localparam logic [7:0]  TO_LAST   = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [2:0]  idx;
  logic [7:0]  cnt;
  logic [7:0]  page0_q, page1_q, page2_q, page3_q;
  logic [3:0]  umb_q;
  logic        en_q;
  logic [2:0]  idx_nxt;
  logic [7:0]  ctrl_q;
  logic        seq_last;

  // Accesses 0..4 map to word offsets 0,0,1,1,2; odd pages use the high byte lane.
  function automatic logic [14:0] acc_adr(input logic [2:0] i);
    return BASE_WORD + {13'd0, i[2:1]};
  endfunction

  function automatic logic [1:0] acc_sel(input logic [2:0] i);
    return (i == 3'd1 || i == 3'd3) ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [7:0] acc_byte(input logic [2:0] i, input logic [7:0] b0,
                                          input logic [7:0] b1, input logic [7:0] b2,
                                          input logic [7:0] b3, input logic [7:0] b4);
    case (i)
      3'd0:    return b0;
      3'd1:    return b1;
      3'd2:    return b2;
      3'd3:    return b3;
      default: return b4;
    endcase
  endfunction

  assign idx_nxt = (idx == 3'd4) ? 3'd0 : idx + 3'd1;
  assign ctrl_q  = {en_q, 3'b000, umb_q};

`ifdef EMS_LOADER_VERIFY_EN
  logic       verify_phase;
  logic [7:0] rd_lane;
  logic [7:0] rd_mask;
  logic       rd_bad;

  // Control readback only cares about the enable bit and the frame base nibble.
  assign rd_lane  = (wbm_sel_o == 2'b10) ? wbm_dat_i[15:8] : wbm_dat_i[7:0];
  assign rd_mask  = (idx == 3'd4) ? 8'h8F : 8'hFF;
  assign rd_bad   = ((rd_lane ^ acc_byte(idx, page0_q, page1_q, page2_q, page3_q, ctrl_q))
                     & rd_mask) != 8'h00;
  assign seq_last = verify_phase;
`else
  logic unused_dat;
  assign unused_dat = ^wbm_dat_i;
  assign seq_last   = 1'b1;
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state     <= IDLE;
      idx       <= 3'd0;
      cnt       <= 8'd0;
      page0_q   <= 8'd0;
      page1_q   <= 8'd0;
      page2_q   <= 8'd0;
      page3_q   <= 8'd0;
      umb_q     <= 4'd0;
      en_q      <= 1'b0;
      wbm_adr_o <= 15'd0;
      wbm_dat_o <= 16'd0;
      wbm_sel_o <= 2'b00;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      error_o   <= 1'b0;
      err_idx_o <= 3'd0;
`ifdef EMS_LOADER_VERIFY_EN
      verify_phase <= 1'b0;
`endif
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE, FINISH: begin
          state <= IDLE;
          if (start_i) begin
            page0_q   <= page0_i;
            page1_q   <= page1_i;
            page2_q   <= page2_i;
            page3_q   <= page3_i;
            umb_q     <= umb_base_i;
            en_q      <= enable_i;
            error_o   <= 1'b0;
            err_idx_o <= 3'd0;
            idx       <= 3'd0;
            cnt       <= 8'd0;
            busy_o    <= 1'b1;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= 1'b1;
            wbm_adr_o <= acc_adr(3'd0);
            wbm_sel_o <= acc_sel(3'd0);
            wbm_dat_o <= {page0_i, page0_i};
            state     <= REQ;
`ifdef EMS_LOADER_VERIFY_EN
            verify_phase <= 1'b0;
`endif
          end
        end
        REQ: begin
          if (wbm_ack_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            state     <= GAP;
`ifdef EMS_LOADER_VERIFY_EN
            if (!wbm_we_o && rd_bad) begin
              error_o   <= 1'b1;
              err_idx_o <= idx;
              busy_o    <= 1'b0;
              done_o    <= 1'b1;
              state     <= FINISH;
            end
`endif
          end else if (cnt == TO_LAST) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            error_o   <= 1'b1;
            err_idx_o <= idx;
            busy_o    <= 1'b0;
            done_o    <= 1'b1;
            state     <= FINISH;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        GAP: begin
          cnt <= 8'd0;
          if (idx == 3'd4 && seq_last) begin
            busy_o <= 1'b0;
            done_o <= 1'b1;
            state  <= FINISH;
          end else begin
            idx       <= idx_nxt;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_adr_o <= acc_adr(idx_nxt);
            wbm_sel_o <= acc_sel(idx_nxt);
            wbm_dat_o <= {2{acc_byte(idx_nxt, page0_q, page1_q, page2_q, page3_q, ctrl_q)}};
            state     <= REQ;
`ifdef EMS_LOADER_VERIFY_EN
            if (idx == 3'd4) begin
              verify_phase <= 1'b1;
              wbm_we_o     <= 1'b0;
            end
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ems_page_loader.sv
// Scoreboard bench for ems_page_loader: stimulus pushes expected bus accesses and completion
// records computed from the access rules; a negedge monitor pops and compares them.
module tb_ems_page_loader;

  localparam int          TIMEOUT   = 16;
  localparam logic [14:0] BASE_WORD = 15'h0104;

  logic        wb_clk_i;
  logic        wb_rst_n_i;
  logic        start_i;
  logic [7:0]  page0_i, page1_i, page2_i, page3_i;
  logic [3:0]  umb_base_i;
  logic        enable_i;
  logic [14:0] wbm_adr_o;
  logic [15:0] wbm_dat_o;
  logic [15:0] wbm_dat_i;
  logic [1:0]  wbm_sel_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic        wbm_ack_i;
  logic        busy_o, done_o, error_o;
  logic [2:0]  err_idx_o;

  ems_page_loader #(.IO_BASE_ADDR(16'h0208), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i), .start_i(start_i),
    .page0_i(page0_i), .page1_i(page1_i), .page2_i(page2_i), .page3_i(page3_i),
    .umb_base_i(umb_base_i), .enable_i(enable_i),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
    .wbm_sel_o(wbm_sel_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_we_o(wbm_we_o), .wbm_ack_i(wbm_ack_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .err_idx_o(err_idx_o)
  );

  typedef struct packed {
    logic [14:0] adr;
    logic [1:0]  sel;
    logic [15:0] dat;
    logic        we;
  } acc_t;

  typedef struct {
    int unsigned tick;
    logic        err;
    logic [2:0]  idx;
    int          leftover;
  } done_t;

  acc_t        exp_acc[$];
  done_t       exp_done[$];
  int          checks = 0;
  int          failures = 0;
  int unsigned tick = 0;

  int          slv_wait = 1;
  int          slv_noack = -1;
  int          slv_bad = -1;
  int          slv_cnt = 0;
  int          slv_idx;
  logic [7:0]  mem [5];

  acc_t        mon_e;
  done_t       mon_d;

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  always @(posedge wb_clk_i) tick <= tick + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h (tick %0d)", name, act, req, tick);
    end
  endtask

  function automatic int accIndex(input logic [14:0] adr, input logic [1:0] sel);
    return int'(adr - BASE_WORD) * 2 + ((sel == 2'b10) ? 1 : 0);
  endfunction

  // Slave: acks in REQ cycle slv_wait+1, stores written bytes and serves them back on reads.
  always @(posedge wb_clk_i) begin
    #1;
    if (wb_rst_n_i && wbm_cyc_o && wbm_stb_o) begin
      slv_cnt++;
      slv_idx = accIndex(wbm_adr_o, wbm_sel_o);
      wbm_ack_i = (slv_cnt == slv_wait + 1) && (slv_idx != slv_noack);
      if (slv_idx >= 0 && slv_idx <= 4) begin
        if (!wbm_we_o)
          wbm_dat_i = (slv_idx == slv_bad) ? 16'h0000 : {mem[slv_idx], mem[slv_idx]};
        if (wbm_ack_i && wbm_we_o)
          mem[slv_idx] = (wbm_sel_o == 2'b10) ? wbm_dat_o[15:8] : wbm_dat_o[7:0];
      end
    end else begin
      slv_cnt   = 0;
      wbm_ack_i = 1'b0;
    end
  end

  // Monitor: every REQ cycle must match the head expectation; ack retires it.
  always @(negedge wb_clk_i) begin
    if (wb_rst_n_i) begin
      if (wbm_cyc_o && wbm_stb_o) begin
        if (exp_acc.size() == 0) begin
          checkOutput("access_expected", exp_acc.size(), 1);
        end else begin
          mon_e = exp_acc[0];
          checkOutput("bus_adr", wbm_adr_o, mon_e.adr);
          checkOutput("bus_sel", wbm_sel_o, mon_e.sel);
          checkOutput("bus_we", wbm_we_o, mon_e.we);
          if (mon_e.we) checkOutput("bus_dat", wbm_dat_o, mon_e.dat);
          if (wbm_ack_i) void'(exp_acc.pop_front());
        end
      end
      if (done_o) begin
        if (exp_done.size() == 0) begin
          checkOutput("done_expected", exp_done.size(), 1);
        end else begin
          mon_d = exp_done.pop_front();
          checkOutput("done_cycle", tick, mon_d.tick);
          checkOutput("done_error", error_o, mon_d.err);
          checkOutput("done_err_idx", err_idx_o, mon_d.idx);
          checkOutput("done_busy", busy_o, 0);
          checkOutput("acc_leftover", exp_acc.size(), mon_d.leftover);
          exp_acc.delete();
        end
      end
    end
  end

  // Drives start at the current negedge and pushes the reference outcome of the sequence.
  task automatic issueStart(input logic [7:0] p0, p1, p2, p3, input logic [3:0] base,
                            input logic en, input int w, input int noack, input int bad,
                            output int unsigned s);
    logic [7:0] b [5];
    int         per;
    done_t      d;
    acc_t       a;
    b = '{p0, p1, p2, p3, {en, 3'b000, base}};
    slv_wait = w; slv_noack = noack; slv_bad = bad;
    page0_i = p0; page1_i = p1; page2_i = p2; page3_i = p3;
    umb_base_i = base; enable_i = en;
    start_i = 1'b1;
    s = tick;
    per = w + 2;
    d.err = 1'b0; d.idx = 3'd0; d.leftover = 0;
    d.tick = s + 5 * per + 1;
    for (int i = 0; i < 5; i++) begin
      a.adr = BASE_WORD + 15'(i / 2);
      a.sel = (i == 1 || i == 3) ? 2'b10 : 2'b01;
      a.dat = {b[i], b[i]};
      a.we  = 1'b1;
      exp_acc.push_back(a);
      if (i == noack) begin
        d.err = 1'b1; d.idx = 3'(i); d.leftover = 1;
        d.tick = s + i * per + TIMEOUT + 1;
        break;
      end
    end
`ifdef EMS_LOADER_VERIFY_EN
    if (!d.err) begin
      d.tick = s + 10 * per + 1;
      for (int i = 0; i < 5; i++) begin
        a.adr = BASE_WORD + 15'(i / 2);
        a.sel = (i == 1 || i == 3) ? 2'b10 : 2'b01;
        a.dat = 16'h0000;
        a.we  = 1'b0;
        exp_acc.push_back(a);
        if (i == bad) begin
          d.err = 1'b1; d.idx = 3'(i);
          d.tick = s + 5 * per + i * per + w + 2;
          break;
        end
      end
    end
`endif
    exp_done.push_back(d);
    @(negedge wb_clk_i);
    start_i = 1'b0;
    checkOutput("busy_after_start", busy_o, 1);
    checkOutput("error_cleared", error_o, 0);
  endtask

  task automatic applyStimulus(input logic [7:0] p0, p1, p2, p3, input logic [3:0] base,
                               input logic en, input int w, input int noack, input int bad,
                               input bit repulse);
    int unsigned s;
    int          guard;
    issueStart(p0, p1, p2, p3, base, en, w, noack, bad, s);
    if (repulse) begin
      repeat (4) @(negedge wb_clk_i);
      start_i = 1'b1; page0_i = ~p0; page3_i = ~p3;
      @(negedge wb_clk_i);
      start_i = 1'b0;
    end
    guard = 0;
    while (exp_done.size() != 0 && guard < 3000) begin
      @(negedge wb_clk_i);
      guard++;
    end
    if (exp_done.size() != 0) begin
      checkOutput("done_seen", exp_done.size(), 0);
      exp_done.delete();
      exp_acc.delete();
    end
    repeat (4) @(negedge wb_clk_i);
    checkOutput("idle_busy", busy_o, 0);
  endtask

  task automatic resetMidSequence();
    int unsigned s;
    issueStart($urandom_range(1, 255), $urandom_range(1, 255), $urandom_range(1, 255),
               $urandom_range(1, 255), 4'h9, 1'b1, 1, -1, -1, s);
    repeat (9) @(negedge wb_clk_i);
    checkOutput("pre_rst_sel", wbm_sel_o, 2'b10);
    #2 wb_rst_n_i = 1'b0;
    #1;
    checkOutput("rst_cyc", wbm_cyc_o, 0);
    checkOutput("rst_stb", wbm_stb_o, 0);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_done", done_o, 0);
    checkOutput("rst_adr", wbm_adr_o, 0);
    exp_acc.delete();
    exp_done.delete();
    @(negedge wb_clk_i);
    wb_rst_n_i = 1'b1;
    applyStimulus(8'hA1, 8'hB2, 8'hC3, 8'hD4, 4'hE, 1'b1, 1, -1, -1, 1'b0);
  endtask

  initial begin
    wb_rst_n_i = 1'b0; start_i = 1'b0;
    page0_i = '0; page1_i = '0; page2_i = '0; page3_i = '0;
    umb_base_i = '0; enable_i = 1'b0; wbm_dat_i = '0; wbm_ack_i = 1'b0;
    for (int i = 0; i < 5; i++) mem[i] = 8'h00;
    #12;
    checkOutput("reset_cyc", wbm_cyc_o, 0);
    checkOutput("reset_busy", busy_o, 0);
    checkOutput("reset_error", error_o, 0);
    checkOutput("reset_adr", wbm_adr_o, 0);
    checkOutput("reset_dat", wbm_dat_o, 0);
    checkOutput("reset_sel", wbm_sel_o, 0);
    @(negedge wb_clk_i);
    wb_rst_n_i = 1'b1;
    @(negedge wb_clk_i);

    applyStimulus(8'h12, 8'h34, 8'h56, 8'h78, 4'hD, 1'b1, 1, -1, -1, 1'b0);
    applyStimulus(8'h12, 8'h34, 8'h56, 8'h78, 4'hD, 1'b1, 1, 2, -1, 1'b0);
    checkOutput("error_hold", error_o, 1);
    checkOutput("err_idx_hold", err_idx_o, 2);
    applyStimulus(8'h01, 8'h02, 8'h03, 8'h04, 4'h5, 1'b0, 1, -1, -1, 1'b1);
    applyStimulus(8'hF0, 8'h0F, 8'h5A, 8'hA5, 4'hC, 1'b1, 3, -1, -1, 1'b0);
    applyStimulus(8'h11, 8'h22, 8'h33, 8'h44, 4'h3, 1'b1, TIMEOUT - 1, -1, -1, 1'b0);
    resetMidSequence();
    applyStimulus(8'h12, 8'h34, 8'h56, 8'h78, 4'hD, 1'b1, 1, -1, 1, 1'b0);

    for (int n = 0; n < 12; n++) begin
      applyStimulus($urandom_range(0, 255), $urandom_range(1, 255), $urandom_range(0, 255),
                    $urandom_range(0, 255), $urandom_range(0, 15), $urandom_range(0, 1),
                    $urandom_range(0, 4),
                    ($urandom_range(0, 9) < 2) ? int'($urandom_range(0, 4)) : -1,
                    ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, 3)) : -1,
                    1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
